sa_drain: RTL and testbench
===========================

SA_DRAIN -- requirements
Module: sa_drain

Interface
REQ-001 Parameter: DW, default 8, width of each result element.
REQ-002 Parameter: N, default 2, array dimension; N*N results drained per tile.
REQ-003 Parameter: LAT, default 5, cycles from start pulse to stable results on s_in; legal range 1..255.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 Port: start  input  1  one-cycle pulse; first operand entered the array this cycle.
REQ-007 Port: s_in  input  [N][N]xDW  accumulator outputs of the array.
REQ-008 Port: out_data  output  DW  current result element.
REQ-009 Port: out_row, out_col  output  $clog2(N) each (min 1)  coordinates of out_data.
REQ-010 Port: out_valid  output  1  out_data/out_row/out_col/out_last valid.
REQ-011 Port: out_ready  input  1  consumer accepts when high together with out_valid.
REQ-012 Port: out_last  output  1  high with element (N-1,N-1).
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: done  output  1  one-cycle pulse after the last transfer.
REQ-015 Port: overrun  output  1  sticky; start seen while busy.

Function
REQ-016 FSM states IDLE, WAIT, DRAIN; IDLE->WAIT on start; WAIT->DRAIN when wait counter equals LAT-1; DRAIN->IDLE on transfer with out_last.
REQ-017 Wait counter clears on entry to WAIT and increments once per cycle in WAIT.
REQ-018 On the WAIT->DRAIN edge all N*N s_in elements are copied into an internal tile buffer in that same cycle; s_in is ignored at all other times.
REQ-019 out_valid is high in every DRAIN cycle and low otherwise; first element is visible the cycle after capture.
REQ-020 Drain order row-major: (0,0),(0,1),...,(N-1,N-1); index advances only on out_valid&&out_ready.
REQ-021 out_data/out_row/out_col/out_last are held stable while out_valid&&!out_ready.
REQ-022 done pulses high in the cycle after the out_last transfer (FSM in IDLE); start in that same cycle is accepted normally.
REQ-023 start while busy is dropped, does not restart the counter, and sets overrun until reset.
REQ-024 Minimum tile period with out_ready held high: 1 + LAT + N*N cycles from start to done.

Reset
REQ-025 rst low asynchronously forces IDLE, counter and drain index to 0, tile buffer to 0, out_valid/out_last/busy/done/overrun to 0.
REQ-026 rst low mid-WAIT or mid-DRAIN aborts the tile with no done pulse; untransferred elements are lost.

Configuration
REQ-027 Macro SA_DRAIN_RELU_EN defined: captured elements are treated as signed two's complement and negative values are stored as 0.
REQ-028 Macro SA_DRAIN_RELU_EN undefined: elements are stored bit-exact.

Structure
REQ-029 Package sa_pkg holds the state enum typedef (IDLE, WAIT, DRAIN) and the default DW/N constants shared with the array.
REQ-030 Single module, no sub-modules; the tile buffer is a flat register array inside sa_drain.

Verification
REQ-031 N=2, LAT=5, ready=1: start at cycle 0, s_in={{1,2},{3,4}} -> out_data 1,2,3,4 on cycles 6..9, out_last at cycle 9, done at cycle 10.
REQ-032 Backpressure: out_ready low on cycles 7-8 -> element 2 held for 3 cycles, order unchanged, done at cycle 12.
REQ-033 start at cycle 3 of a tile -> dropped, overrun=1 and held, tile completes normally.
REQ-034 rst low at cycle 7 -> out_valid=0 and busy=0 immediately, no done; a new start then drains a fresh tile.
REQ-035 RELU_EN defined, s_in={{8'hFF,8'h7F},{8'h80,8'h00}} -> 0,127,0,0; undefined -> 255,127,128,0.
REQ-036 s_in changed after capture cycle -> drained values equal the capture-cycle values.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array drain path: FSM state encoding
// and the default element width / array dimension used by the array itself.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int SA_DW = 8;
    localparam int SA_N  = 2;

endpackage

// File: rtl/sa_drain.sv
// Drains an N x N systolic-array result tile, row-major, over a valid/ready port.
// Optional macro SA_DRAIN_RELU_EN clamps negative captured elements to zero.
module sa_drain
    import sa_pkg::*;
#(
    parameter int DW  = SA_DW,
    parameter int N   = SA_N,
    parameter int LAT = 5,
    localparam int RW = (N > 1) ? $clog2(N) : 1,
    localparam int IW = (N > 1) ? $clog2(N * N) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N-1:0][N-1:0][DW-1:0]   s_in,
    output logic [DW-1:0]                 out_data,
    output logic [RW-1:0]                 out_row,
    output logic [RW-1:0]                 out_col,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);

    state_t          state_q;
    logic [7:0]      cnt_q;
    logic [RW-1:0]   row_q, row_d;
    logic [RW-1:0]   col_q, col_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   tile_q [N*N];
    logic            done_q;
    logic            overrun_q;

    function automatic logic [DW-1:0] capVal(input logic [DW-1:0] v);
`ifdef SA_DRAIN_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (row_q == RW'(N - 1)) && (col_q == RW'(N - 1));
    assign out_data  = tile_q[idx_q];
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

    // Row-major successor of the current drain coordinate.
    always_comb begin
        row_d = row_q;
        col_d = col_q + RW'(1);
        idx_d = idx_q + IW'(1);
        if (col_q == RW'(N - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < N * N; i++) begin
                tile_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    // Results are only stable once, so s_in is sampled on this single edge.
                    if (cnt_q == 8'(LAT - 1)) begin
                        state_q <= DRAIN;
                        row_q   <= '0;
                        col_q   <= '0;
                        idx_q   <= '0;
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                tile_q[IW'(r * N + c)] <= capVal(s_in[r][c]);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            row_q   <= '0;
                            col_q   <= '0;
                            idx_q   <= '0;
                        end else begin
                            row_q <= row_d;
                            col_q <= col_d;
                            idx_q <= idx_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_drain.sv
// Directed bench for sa_drain (N=2, LAT=5, DW=8); expectations follow the
// SA_DRAIN_RELU_EN setting used for the build.
module tb_sa_drain;

    localparam int DW  = 8;
    localparam int N   = 2;
    localparam int LAT = 5;

    logic                        clk;
    logic                        rst;
    logic                        start;
    logic [N-1:0][N-1:0][DW-1:0] s_in;
    logic [DW-1:0]               out_data;
    logic [0:0]                  out_row;
    logic [0:0]                  out_col;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic                        busy;
    logic                        done;
    logic                        overrun;

    int nCompared;
    int nMismatched;
    bit ovExp;

    sa_drain #(.DW(DW), .N(N), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_in      (s_in),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison; every check is counted here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic setTile(input logic [31:0] v);
        for (int i = 0; i < N * N; i++) begin
            s_in[i / N][i % N] = v[8*i +: 8];
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Starts a tile in the current cycle (cycle 0) and tracks the drain with a
    // small reference model: the first element appears at cycle LAT+1, the index
    // advances on each accepted transfer, done follows the last transfer.
    task automatic applyStimulus(input logic [31:0] vals, input logic [31:0] expD,
                                 input logic [63:0] readyLow, input int strayStart,
                                 input bit changeAfter, input int expDoneCyc);
        int  k;
        int  doneCyc;
        bit  expValid;
        setTile(vals);
        start     = 1'b1;
        out_ready = !readyLow[0];
        k         = 0;
        doneCyc   = -1;
        for (int c = 1; c <= 40 && doneCyc < 0; c++) begin
            nextCycle();
            start     = (c == strayStart);
            out_ready = !readyLow[c];
            if (changeAfter && c == LAT + 1) setTile(~vals);
            if (c == strayStart + 1 && strayStart > 0) ovExp = 1'b1;
            if (k == N * N) begin
                checkOutput("done", {31'd0, done}, 32'd1);
                checkOutput("validAfter", {31'd0, out_valid}, 32'd0);
                checkOutput("busyAfter", {31'd0, busy}, 32'd0);
                doneCyc = c;
            end else begin
                expValid = (c >= LAT + 1);
                checkOutput("valid", {31'd0, out_valid}, {31'd0, expValid});
                checkOutput("busy", {31'd0, busy}, 32'd1);
                checkOutput("doneEarly", {31'd0, done}, 32'd0);
                if (expValid) begin
                    checkOutput("data", {24'd0, out_data}, {24'd0, expD[8*k +: 8]});
                    checkOutput("row", {31'd0, out_row}, k / N);
                    checkOutput("col", {31'd0, out_col}, k % N);
                    checkOutput("last", {31'd0, out_last}, {31'd0, k == N * N - 1});
                    if (out_ready) k++;
                end
            end
        end
        checkOutput("doneCycle", doneCyc, expDoneCyc);
        checkOutput("overrun", {31'd0, overrun}, {31'd0, ovExp});
        out_ready = 1'b1;
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        ovExp       = 1'b0;
        rst         = 1'b0;
        start       = 1'b0;
        out_ready   = 1'b1;
        s_in        = '0;

        #12;
        checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstOverrun", {31'd0, overrun}, 32'd0);
        checkOutput("rstLast", {31'd0, out_last}, 32'd0);
        nextCycle();
        rst = 1'b1;
        nextCycle();

        $display("[TB] basic drain, s_in modified after capture");
        applyStimulus(32'h04030201, 32'h04030201, 64'd0, 0, 1'b1, 10);

        $display("[TB] backpressure, started in the done cycle");
        applyStimulus(32'h08070605, 32'h08070605, 64'h180, 0, 1'b0, 12);

        $display("[TB] stray start during WAIT");
        applyStimulus(32'h0C0B0A09, 32'h0C0B0A09, 64'd0, 3, 1'b0, 10);
        nextCycle();
        checkOutput("overrunSticky", {31'd0, overrun}, 32'd1);

        $display("[TB] reset mid-drain");
        setTile(32'h44332211);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        repeat (6) nextCycle();
        checkOutput("preRstValid", {31'd0, out_valid}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abortValid", {31'd0, out_valid}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortOverrun", {31'd0, overrun}, 32'd0);
        ovExp = 1'b0;
        nextCycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput("noDone", {31'd0, done}, 32'd0);
            checkOutput("idleValid", {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] signed boundary values after reset");
`ifdef SA_DRAIN_RELU_EN
        applyStimulus(32'h00807FFF, 32'h00007F00, 64'd0, 0, 1'b0, 10);
`else
        applyStimulus(32'h00807FFF, 32'h00807FFF, 64'd0, 0, 1'b0, 10);
`endif

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
